mpc_sequencer: RTL and testbench

//  Microprogram sequencer: reading end of the control store. Consumes the next-address/JAM fields from the control-store

---
 rtl/mpc_sequencer.sv | 133 +++++++++++++
 tb/tb_mpc_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_sequencer.sv
// Microprogram sequencer: forms the next control-store address from the
// NEXT_ADDRESS/JAM fields, ALU flags and MBR, and adds run/halt/step control,
// a memory-wait stall and saturating retire/stall counters.
module mpc_sequencer #(
    parameter logic [8:0]  RESET_ADDR = 9'h000,
    parameter logic [8:0]  HALT_ADDR  = 9'h1FF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [8:0]       next_addr,
    input  logic [2:0]       jam,
    input  logic [2:0]       mem,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic [7:0]       mbr,
    input  logic             mem_wait,
    output logic [8:0]       mpc,
    output logic             rom_read,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] ucycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStall,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [8:0]       mpc_q, mpc_d;
    logic [CNT_W-1:0] ucnt_q, ucnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             n_q, n_d;
    logic             z_q, z_d;

    logic [8:0]       nxt;
    logic             adv;

    // Next-address function: JMPC ORs MBR into the low byte, JAMN/JAMZ force bit 8.
    always_comb begin
        nxt = next_addr;
        if (jam[2]) begin
            nxt[7:0] = next_addr[7:0] | mbr;
        end
        if ((jam[1] & alu_n) | (jam[0] & alu_z)) begin
            nxt[8] = 1'b1;
        end
    end

    // A wait always wins over a step pulse; the pulse is simply lost.
    assign adv = (step_mode ? step : 1'b1) & ~mem_wait;

    // Next-state, next-address and counter update.
    always_comb begin
        state_d = state_q;
        mpc_d   = mpc_q;
        ucnt_d  = ucnt_q;
        scnt_d  = scnt_q;
        n_d     = n_q;
        z_d     = z_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (adv) begin
                    mpc_d  = nxt;
                    ucnt_d = (ucnt_q == {CNT_W{1'b1}}) ? ucnt_q : ucnt_q + 1'b1;
                    n_d    = alu_n;
                    z_d    = alu_z;
                    if (nxt == HALT_ADDR) begin
                        state_d = StHalt;
                    end
                end else if (mem_wait && (mem != 3'b000)) begin
                    state_d = StStall;
                end
            end
            StStall: begin
                scnt_d = (scnt_q == {CNT_W{1'b1}}) ? scnt_q : scnt_q + 1'b1;
                // Exit cycle only returns to RUN; the advance happens next cycle.
                if (!mem_wait) begin
                    state_d = StRun;
                end
            end
            StHalt: begin
                if (start) begin
                    mpc_d   = RESET_ADDR;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, address, flag latches and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            mpc_q   <= RESET_ADDR;
            ucnt_q  <= '0;
            scnt_q  <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            ucnt_q  <= ucnt_d;
            scnt_q  <= scnt_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    // Status outputs decoded from the state register.
    assign mpc        = mpc_q;
    assign running    = (state_q == StRun) || (state_q == StStall);
    assign rom_read   = running;
    assign halted     = (state_q == StHalt);
    assign ucycle_cnt = ucnt_q;
    assign stall_cnt  = scnt_q;

endmodule

// File: tb/tb_mpc_sequencer.sv
// Self-checking bench for mpc_sequencer: vector table, directed corner
// sequences and a randomized run checked against a behavioural model.
module tb_mpc_sequencer;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [8:0] RST_A = 9'h000;
    localparam logic [8:0] HLT_A = 9'h1FF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, step_mode, step;
    logic [8:0]    next_addr;
    logic [2:0]    jam, mem;
    logic          alu_n, alu_z;
    logic [7:0]    mbr;
    logic          mem_wait;
    logic [8:0]    mpc;
    logic          rom_read, running, halted;
    logic [CW-1:0] ucycle_cnt, stall_cnt;

    mpc_sequencer #(
        .RESET_ADDR(RST_A),
        .HALT_ADDR (HLT_A),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step_mode (step_mode),
        .step      (step),
        .next_addr (next_addr),
        .jam       (jam),
        .mem       (mem),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .mbr       (mbr),
        .mem_wait  (mem_wait),
        .mpc       (mpc),
        .rom_read  (rom_read),
        .running   (running),
        .halted    (halted),
        .ucycle_cnt(ucycle_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle 1=run 2=stall 3=halt.
    int m_mode;
    int m_mpc;
    int m_ucnt;
    int m_scnt;

    function automatic int model_nxt();
        int a;
        a = int'(next_addr);
        if (jam[2]) a = (a & 'h100) | ((a & 'hFF) | int'(mbr));
        if ((jam[1] && alu_n) || (jam[0] && alu_z)) a = a | 'h100;
        return a;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_mpc  = int'(RST_A);
        m_ucnt = 0;
        m_scnt = 0;
    endtask

    task automatic model_step();
        bit go;
        int a;
        case (m_mode)
            0: if (start) m_mode = 1;
            1: begin
                go = (step_mode ? step : 1'b1) && !mem_wait;
                if (go) begin
                    a = model_nxt();
                    m_mpc = a;
                    if (m_ucnt < CMAX) m_ucnt++;
                    if (a == int'(HLT_A)) m_mode = 3;
                end else if (mem_wait && mem != 3'b000) begin
                    m_mode = 2;
                end
            end
            2: begin
                if (m_scnt < CMAX) m_scnt++;
                if (!mem_wait) m_mode = 1;
            end
            default: if (start) begin
                m_mpc  = int'(RST_A);
                m_mode = 1;
            end
        endcase
    endtask

    task automatic check_model();
        bit act_run;
        act_run = (m_mode == 1) || (m_mode == 2);
        chk("model mpc", int'(mpc), m_mpc);
        chk("model running", int'(running), int'(act_run));
        chk("model rom_read", int'(rom_read), int'(act_run));
        chk("model halted", int'(halted), int'(m_mode == 3));
        chk("model ucycle_cnt", int'(ucycle_cnt), m_ucnt);
        chk("model stall_cnt", int'(stall_cnt), m_scnt);
    endtask

    // One rising edge: model follows the same sampled inputs, then compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic quiet();
        start = 0; step_mode = 0; step = 0; next_addr = 9'h000; jam = 3'b000;
        mem = 3'b000; alu_n = 0; alu_z = 0; mbr = 8'h00; mem_wait = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 model_reset();
        check_model();
        chk("reset mpc", int'(mpc), 0);
        chk("reset running", int'(running), 0);
        chk("reset ucycle_cnt", int'(ucycle_cnt), 0);
        chk("reset stall_cnt", int'(stall_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       st;
        logic [8:0] na;
        logic [2:0] jm;
        logic [2:0] mm;
        logic       n;
        logic       z;
        logic [7:0] mb;
        logic       mw;
        logic [8:0] e_mpc;
        logic       e_run;
        int         e_ucnt;
    } vec_t;

    vec_t tbl[12];
    int   u0;

    initial begin
        tbl[0]  = '{1'b1, 9'h000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 9'h000, 1'b1, 0};
        tbl[1]  = '{1'b0, 9'h005, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 9'h005, 1'b1, 1};
        tbl[2]  = '{1'b0, 9'h100, 3'b100, 3'b000, 1'b0, 1'b0, 8'h36, 1'b0, 9'h136, 1'b1, 2};
        tbl[3]  = '{1'b0, 9'h020, 3'b010, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 9'h120, 1'b1, 3};
        tbl[4]  = '{1'b0, 9'h020, 3'b010, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 9'h020, 1'b1, 4};
        tbl[5]  = '{1'b0, 9'h020, 3'b011, 3'b000, 1'b0, 1'b1, 8'h00, 1'b0, 9'h120, 1'b1, 5};
        tbl[6]  = '{1'b0, 9'h020, 3'b011, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 9'h120, 1'b1, 6};
        tbl[7]  = '{1'b0, 9'h040, 3'b110, 3'b000, 1'b1, 1'b0, 8'h12, 1'b0, 9'h152, 1'b1, 7};
        tbl[8]  = '{1'b0, 9'h0FF, 3'b100, 3'b000, 1'b0, 1'b0, 8'h01, 1'b0, 9'h0FF, 1'b1, 8};
        tbl[9]  = '{1'b0, 9'h033, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 9'h0FF, 1'b1, 8};
        tbl[10] = '{1'b0, 9'h033, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 9'h033, 1'b1, 9};
        tbl[11] = '{1'b1, 9'h044, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 9'h044, 1'b1, 10};

        quiet();
        reset = 1'b0;
        model_reset();
        #2;
        check_model();
        chk("reset mpc", int'(mpc), 0);
        chk("reset rom_read", int'(rom_read), 0);
        @(negedge clk);
        reset = 1'b1;

        // Vector table: next-address function and basic run control.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = tbl[i].st; next_addr = tbl[i].na; jam = tbl[i].jm; mem = tbl[i].mm;
            alu_n = tbl[i].n; alu_z = tbl[i].z; mbr = tbl[i].mb; mem_wait = tbl[i].mw;
            cycle();
            chk($sformatf("vec%0d mpc", i), int'(mpc), int'(tbl[i].e_mpc));
            chk($sformatf("vec%0d running", i), int'(running), int'(tbl[i].e_run));
            chk($sformatf("vec%0d ucycle_cnt", i), int'(ucycle_cnt), tbl[i].e_ucnt);
        end

        // Memory wait with an active mem request: three wait cycles -> stall.
        @(negedge clk); quiet(); next_addr = 9'h060; mem = 3'b010; mem_wait = 1;
        cycle(); cycle(); cycle();
        chk("stall mpc frozen", int'(mpc), 'h044);
        @(negedge clk); mem_wait = 0;
        cycle();
        chk("stall_cnt after wait", int'(stall_cnt), 3);
        chk("stall exit no advance", int'(mpc), 'h044);
        @(negedge clk); mem = 3'b000;
        cycle();
        chk("resume mpc", int'(mpc), 'h060);
        chk("resume ucycle_cnt", int'(ucycle_cnt), 11);

        // Single-step: two pulses five cycles apart give exactly two advances.
        u0 = int'(ucycle_cnt);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            step_mode = 1; next_addr = 9'(9'h070 + i); step = (i == 2 || i == 7);
            cycle();
        end
        chk("step advances", int'(ucycle_cnt) - u0, 2);
        chk("step second mpc", int'(mpc), 'h077);
        @(negedge clk); step = 1; mem_wait = 1; next_addr = 9'h0AA;
        cycle();
        @(negedge clk); step = 0; mem_wait = 0;
        cycle();
        chk("step during wait dropped", int'(mpc), 'h077);
        chk("step dropped count", int'(ucycle_cnt), 13);

        // Halt and restart.
        @(negedge clk); quiet(); next_addr = HLT_A;
        cycle();
        chk("halt halted", int'(halted), 1);
        chk("halt rom_read", int'(rom_read), 0);
        chk("halt mpc", int'(mpc), 'h1FF);
        @(negedge clk); next_addr = 9'h005;
        cycle();
        chk("halt holds", int'(mpc), 'h1FF);
        @(negedge clk); start = 1;
        cycle();
        chk("restart mpc", int'(mpc), 0);
        chk("restart running", int'(running), 1);

        // Reset in the middle of a stall.
        @(negedge clk); quiet(); mem = 3'b001; mem_wait = 1;
        cycle(); cycle();
        chk("pre-reset stall", int'(stall_cnt), 4);
        do_reset();

        // Retire counter saturates instead of wrapping.
        quiet(); start = 1;
        cycle();
        @(negedge clk); start = 0; next_addr = 9'h010;
        for (int i = 0; i < 20; i++) cycle();
        chk("ucycle_cnt saturates", int'(ucycle_cnt), CMAX);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(15) == 0);
            if ($urandom_range(15) == 0) step_mode = ~step_mode;
            step      = ($urandom_range(2) == 0);
            next_addr = ($urandom_range(63) == 0) ? HLT_A : 9'($urandom);
            jam       = 3'($urandom);
            mem       = $urandom_range(1) ? 3'($urandom) : 3'b000;
            alu_n     = 1'($urandom);
            alu_z     = 1'($urandom);
            mbr       = 8'($urandom);
            mem_wait  = ($urandom_range(3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
